vae_recon_scorer: RTL and testbench
===================================

VAE_RECON_SCORER -- requirements
Module: vae_recon_scorer

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, width of one Q6.10 signed feature word.
REQ-002 Parameter: N_FEAT, default 9, features per vector; fixed at 9 for this release.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  one-cycle request to score the vectors currently on x_vec/a3_vec.
REQ-006 clr  input  1  synchronous clear of anomaly_cnt.
REQ-007 x_vec  input  144  original feature vector, Q6.10 signed; feature k (1..9) on bits [16k-1:16k-16].
REQ-008 a3_vec  input  144  decoder reconstruction (a3_1..a3_9 of the forward VAE), same packing as x_vec.
REQ-009 threshold  input  32  unsigned anomaly threshold on the Q22.10 score.
REQ-010 busy  output  1  high while a scoring job is in progress.
REQ-011 done  output  1  one-cycle pulse when score/anomaly are updated.
REQ-012 score  output  32  unsigned Q22.10 sum of squared reconstruction errors.
REQ-013 anomaly  output  1  high when score > threshold; valid from done until next done.
REQ-014 anomaly_cnt  output  16  count of anomalous jobs since reset/clr.

Function
REQ-015 FSM states IDLE, ACC, DONE; the only transitions are IDLE->ACC on start, ACC->DONE after 9 features, and DONE->IDLE unconditionally.
REQ-016 In IDLE, start=1 at edge E0 SHALL latch x_vec, a3_vec and threshold, clear the accumulator, clear the feature index, and set busy.
REQ-017 At edges E1..E9 the block SHALL process features 1..9 in order, one per edge.
REQ-018 Per feature: diff = x_k - a3_k, 17-bit signed; sq = diff*diff, unsigned 34-bit; term = sq >> 10, floor truncation.
REQ-019 Accumulator SHALL be 32-bit unsigned; max sum 9*4194176 < 2^31, so no saturation logic is required.
REQ-020 At E10 the block SHALL register score = accumulator and anomaly = (score > threshold) as a strict unsigned compare; done=1 and busy=0 for the cycle after E10.
REQ-021 Latency SHALL be exactly 10 clocks from the start edge to the done edge; throughput is one job per 11 clocks.
REQ-022 start while in ACC or DONE SHALL be ignored (no queuing); latched operands are unaffected by input changes during a job.
REQ-023 score and anomaly SHALL hold their values until the next done.
REQ-024 At E10, if anomaly=1, anomaly_cnt SHALL increment, saturating at 0xFFFF.
REQ-025 clr=1 SHALL zero anomaly_cnt at that edge; clr wins over a simultaneous increment.
REQ-026 clr SHALL NOT affect the FSM, score or anomaly.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, clear the feature index and the accumulator, and drive busy, done, score, anomaly and anomaly_cnt to 0.
REQ-028 A reset asserted mid-job SHALL abandon the job with no done pulse; the first start after rst deasserts begins a fresh job.

Verification
REQ-029 x_vec = a3_vec = all 0x0400, threshold 0, start -> done exactly 10 clocks later, score 0, anomaly 0, anomaly_cnt 0.
REQ-030 x all 0x0400, a3 all 0x0000, threshold 9215 -> score 9216, anomaly 1, cnt 1; repeat with threshold 9216 -> anomaly 0, cnt stays 1.
REQ-031 x_1 = 0x8000, a3_1 = 0x7FFF, all other features equal -> score 4194176, which exercises the negative extreme diff and floor truncation.
REQ-032 Second start pulses at E3 and at the done cycle -> both ignored; operands changed mid-job do not alter the score; a start one clock after done is accepted.
REQ-033 rst pulsed at E5 of a job -> all outputs 0 immediately, no done pulse; the next job scores correctly.
REQ-034 anomaly_cnt preloaded to 0xFFFF via repeated anomalous jobs (or force) -> stays 0xFFFF; clr coincident with an anomalous done -> cnt 0.

Source files
------------

// File: rtl/vae_recon_scorer.sv
// VAE reconstruction scorer: sums the floor(diff^2 / 1024) error over the 9 features
// of a latched x/a3 vector pair, one feature per clock, and flags scores above threshold.
module vae_recon_scorer #(
   parameter int DATA_WIDTH = 16,
   parameter int N_FEAT     = 9
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         clr,
   input  logic [N_FEAT*DATA_WIDTH-1:0] x_vec,
   input  logic [N_FEAT*DATA_WIDTH-1:0] a3_vec,
   input  logic [31:0]                  threshold,
   output logic                         busy,
   output logic                         done,
   output logic [31:0]                  score,
   output logic                         anomaly,
   output logic [15:0]                  anomaly_cnt
);

   localparam int IW = $clog2(N_FEAT + 1);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t                              state_q, state_d;
   logic [N_FEAT-1:0][DATA_WIDTH-1:0]   x_l, a_l;
   logic [31:0]                         thr_l;
   logic [31:0]                         acc;
   logic [IW-1:0]                       idx;

   logic [DATA_WIDTH-1:0]               x_cur, a_cur;
   logic signed [DATA_WIDTH:0]          diff;
   logic signed [2*DATA_WIDTH+1:0]      diff_x, sq;
   logic [31:0]                         term;
   logic                                over;

   // Sign-extend both operands by one bit so the most negative diff (-65535) is exact.
   assign x_cur  = x_l[idx];
   assign a_cur  = a_l[idx];
   assign diff   = {x_cur[DATA_WIDTH-1], x_cur} - {a_cur[DATA_WIDTH-1], a_cur};
   assign diff_x = diff;
   assign sq     = diff_x * diff_x;
   assign term   = 32'($unsigned(sq) >> 10);
   assign over   = acc > thr_l;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ACC;
         ACC:     if (idx == IW'(N_FEAT - 1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         x_l     <= '0;
         a_l     <= '0;
         thr_l   <= '0;
         acc     <= '0;
         idx     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         score   <= '0;
         anomaly <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               x_l   <= x_vec;
               a_l   <= a3_vec;
               thr_l <= threshold;
               acc   <= '0;
               idx   <= '0;
               busy  <= 1'b1;
            end
            ACC: begin
               acc <= acc + term;
               idx <= idx + 1'b1;
            end
            DONE: begin
               score   <= acc;
               anomaly <= over;
               done    <= 1'b1;
               busy    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // clr takes priority over a same-edge increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         anomaly_cnt <= '0;
      else if (clr)
         anomaly_cnt <= '0;
      else if (state_q == DONE && over && anomaly_cnt != 16'hFFFF)
         anomaly_cnt <= anomaly_cnt + 1'b1;
   end

endmodule

// File: tb/tb_vae_recon_scorer.sv
// Bench for vae_recon_scorer: directed and random jobs checked against an
// arithmetic model of the reconstruction score and an anomaly counter model.
module tb_vae_recon_scorer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         clr = 1'b0;
   logic [143:0] x_vec = '0;
   logic [143:0] a3_vec = '0;
   logic [31:0]  threshold = '0;
   logic         busy, done, anomaly;
   logic [31:0]  score;
   logic [15:0]  anomaly_cnt;

   int           n_chk = 0;
   int           n_fail = 0;
   logic [15:0]  cnt_m = '0;

   vae_recon_scorer #(.DATA_WIDTH(16), .N_FEAT(9)) dut (
      .clk(clk), .rst(rst), .start(start), .clr(clr),
      .x_vec(x_vec), .a3_vec(a3_vec), .threshold(threshold),
      .busy(busy), .done(done), .score(score), .anomaly(anomaly),
      .anomaly_cnt(anomaly_cnt)
   );

   always #5 clk = ~clk;

   function automatic longint model(input logic [143:0] x, input logic [143:0] a);
      longint s = 0;
      for (int k = 0; k < 9; k++) begin
         logic [15:0] xw, aw;
         longint d;
         xw = x[k*16 +: 16];
         aw = a[k*16 +: 16];
         d  = longint'($signed(xw)) - longint'($signed(aw));
         s += (d * d) / 1024;
      end
      return s;
   endfunction

   function automatic logic [143:0] fill(input logic [15:0] w);
      logic [143:0] v;
      for (int k = 0; k < 9; k++) v[k*16 +: 16] = w;
      return v;
   endfunction

   function automatic logic [143:0] rand_vec();
      logic [143:0] v;
      for (int k = 0; k < 9; k++) v[k*16 +: 16] = 16'($urandom);
      return v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called just after the negedge following the start edge; returns clocks to done.
   task automatic wait_done(input bit clr_done, output int n);
      n = 0;
      while (!done && n < 30) begin
         if (clr_done && n == 9) clr = 1'b1;
         @(negedge clk);
         n++;
      end
      clr = 1'b0;
   endtask

   task automatic run_job(input string tag, input logic [143:0] x, input logic [143:0] a,
                          input logic [31:0] thr, input bit clr_done);
      longint s;
      bit     an;
      int     n;
      s  = model(x, a);
      an = (s > longint'(thr));
      @(negedge clk);
      x_vec = x; a3_vec = a; threshold = thr; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      wait_done(clr_done, n);
      if (clr_done) cnt_m = '0;
      else if (an && cnt_m != 16'hFFFF) cnt_m++;
      chk({tag, "_lat"}, 64'(n), 64'd10);
      chk({tag, "_score"}, 64'(score), 64'(s));
      chk({tag, "_anom"}, 64'(anomaly), 64'(an));
      chk({tag, "_cnt"}, 64'(anomaly_cnt), 64'(cnt_m));
      chk({tag, "_idlebusy"}, 64'(busy), 64'd0);
      @(negedge clk);
      chk({tag, "_donepulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      logic [143:0] x1, a1, x2, a2, xo;
      logic [31:0]  thr1;
      longint       s1, s2, sr;
      int           n;
      bit           saw;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_score", 64'(score), 64'd0);
      chk("rst_anom", 64'(anomaly), 64'd0);
      chk("rst_cnt", 64'(anomaly_cnt), 64'd0);
      rst = 1'b0;

      // Zero error, equal vectors
      run_job("zero", fill(16'h0400), fill(16'h0400), 32'd0, 1'b0);
      // Strict compare boundary around 9216
      run_job("thr_lo", fill(16'h0400), fill(16'h0000), 32'd9215, 1'b0);
      run_job("thr_eq", fill(16'h0400), fill(16'h0000), 32'd9216, 1'b0);
      chk("thr_const", 64'(score), 64'd9216);
      // Negative extreme diff with floor truncation
      x1 = fill(16'h1234); a1 = x1;
      x1[15:0] = 16'h8000; a1[15:0] = 16'h7FFF;
      run_job("extreme", x1, a1, 32'd0, 1'b0);
      chk("extreme_const", 64'(score), 64'd4194176);

      // Ignored starts mid-job and in DONE, operand changes mid-job, start right after done
      x1 = rand_vec(); a1 = rand_vec(); x2 = rand_vec(); a2 = rand_vec();
      s1 = model(x1, a1); s2 = model(x2, a2);
      thr1 = 32'(s1 / 2);
      @(negedge clk);
      x_vec = x1; a3_vec = a1; threshold = thr1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      x_vec = x2; a3_vec = a2; threshold = 32'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      chk("ign_done", 64'(done), 64'd1);
      chk("ign_score", 64'(score), 64'(s1));
      chk("ign_anom", 64'(anomaly), 64'(s1 > longint'(thr1)));
      if (s1 > longint'(thr1) && cnt_m != 16'hFFFF) cnt_m++;
      chk("ign_cnt", 64'(anomaly_cnt), 64'(cnt_m));
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", 64'(busy), 64'd1);
      chk("b2b_nodone", 64'(done), 64'd0);
      wait_done(1'b0, n);
      chk("b2b_lat", 64'(n), 64'd10);
      chk("b2b_score", 64'(score), 64'(s2));
      chk("b2b_anom", 64'(anomaly), 64'(s2 > 0));
      if (s2 > 0 && cnt_m != 16'hFFFF) cnt_m++;
      chk("b2b_cnt", 64'(anomaly_cnt), 64'(cnt_m));
      saw = 1'b0;
      repeat (12) begin @(negedge clk); if (done || busy) saw = 1'b1; end
      chk("b2b_noextra", 64'(saw), 64'd0);

      // Reset mid-job
      xo = fill(16'h0400);
      @(negedge clk);
      x_vec = xo; a3_vec = '0; threshold = 32'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      cnt_m = '0;
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_done", 64'(done), 64'd0);
      chk("mrst_score", 64'(score), 64'd0);
      chk("mrst_anom", 64'(anomaly), 64'd0);
      chk("mrst_cnt", 64'(anomaly_cnt), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      saw = 1'b0;
      repeat (15) begin @(negedge clk); if (done) saw = 1'b1; end
      chk("mrst_nodone", 64'(saw), 64'd0);
      run_job("after_rst", xo, 144'd0, 32'd100, 1'b0);

      // Random jobs, threshold placed just around the model score
      for (int j = 0; j < 6; j++) begin
         x1 = rand_vec(); a1 = rand_vec();
         if (j % 2 == 1) a1[143:16] = x1[143:16];
         sr = model(x1, a1);
         case (j % 3)
            0:       thr1 = 32'(sr);
            1:       thr1 = 32'(sr - 1);
            default: thr1 = 32'($urandom);
         endcase
         run_job("rand", x1, a1, thr1, 1'b0);
      end

      // Counter saturation and clr priority
      force dut.anomaly_cnt = 16'hFFFE;
      @(negedge clk);
      release dut.anomaly_cnt;
      cnt_m = 16'hFFFE;
      chk("sat_preload", 64'(anomaly_cnt), 64'hFFFE);
      run_job("sat1", fill(16'h0400), '0, 32'd0, 1'b0);
      chk("sat1_const", 64'(anomaly_cnt), 64'hFFFF);
      run_job("sat2", fill(16'h0400), '0, 32'd0, 1'b0);
      chk("sat2_const", 64'(anomaly_cnt), 64'hFFFF);
      run_job("clrwin", fill(16'h0400), '0, 32'd0, 1'b1);
      chk("clrwin_const", 64'(anomaly_cnt), 64'd0);

      // clr while idle leaves score and anomaly alone
      run_job("preclr", fill(16'h0400), '0, 32'd5, 1'b0);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      cnt_m = '0;
      chk("clr_cnt", 64'(anomaly_cnt), 64'd0);
      chk("clr_score", 64'(score), 64'd9216);
      chk("clr_anom", 64'(anomaly), 64'd1);
      chk("clr_busy", 64'(busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
